// File: rtl/inst_fetch_arbiter.sv
// Arbitrates the instruction ROM address port between fetch and debug, returning registered responses one cycle after grant.
// Optional misaligned-fetch detection is enabled by defining FETCH_ALIGN_CHECK_EN.
module inst_fetch_arbiter #(
   parameter int ROM_DEPTH  = 24,
   parameter int STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        if_req,
   input  logic [31:0] if_pc,
   output logic        if_gnt,
   output logic        if_rvalid,
   output logic [31:0] if_inst,
   output logic        if_adel,
   input  logic        dbg_req,
   input  logic [4:0]  dbg_addr,
   output logic        dbg_gnt,
   output logic        dbg_rvalid,
   output logic [31:0] dbg_data,
   output logic [4:0]  rom_addr,
   input  logic [31:0] rom_inst
);

   // State bits double as the registered rvalid outputs.
   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      IF_RESP  = 2'b01,
      DBG_RESP = 2'b10
   } state_t;

   localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

   state_t      state_r;
   logic [2:0]  dbg_wait_r;
   logic [4:0]  rom_addr_r;
   logic [31:0] if_inst_r;
   logic [31:0] dbg_data_r;
   logic        if_gnt_s;
   logic        dbg_gnt_s;
   logic        starve_s;
   logic [4:0]  rom_addr_s;
   logic [31:0] rom_word_s;
   logic [31:0] if_data_s;
   logic        if_high_s;
   logic        misalign_s;

   function automatic logic word_in_range(input logic [4:0] idx);
      return ({27'd0, idx} < 32'(ROM_DEPTH));
   endfunction

   // Grant selection: fetch has priority until debug has waited STARVE_MAX cycles.
   always_comb begin
      starve_s  = (dbg_wait_r == STARVE_LIM);
      if_gnt_s  = 1'b0;
      dbg_gnt_s = 1'b0;
      if (!resetn) begin
         if_gnt_s  = 1'b0;
         dbg_gnt_s = 1'b0;
      end else if (if_req && !(dbg_req && starve_s)) begin
         if_gnt_s = 1'b1;
      end else if (dbg_req) begin
         dbg_gnt_s = 1'b1;
      end else begin
         if_gnt_s  = 1'b0;
         dbg_gnt_s = 1'b0;
      end
   end

   // ROM address mux and out-of-range data masking.
   always_comb begin
      if (if_gnt_s) begin
         rom_addr_s = if_pc[6:2];
      end else if (dbg_gnt_s) begin
         rom_addr_s = dbg_addr;
      end else begin
         rom_addr_s = rom_addr_r;
      end
      rom_word_s = word_in_range(rom_addr_s) ? rom_inst : 32'h0000_0000;
      if_high_s  = (if_pc[31:7] != 25'd0);
`ifdef FETCH_ALIGN_CHECK_EN
      misalign_s = (if_pc[1:0] != 2'b00);
`else
      misalign_s = 1'b0;
`endif
      if (if_high_s || misalign_s) begin
         if_data_s = 32'h0000_0000;
      end else begin
         if_data_s = rom_word_s;
      end
   end

   // Address hold register and debug starvation counter.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rom_addr_r <= 5'd0;
         dbg_wait_r <= 3'd0;
      end else begin
         rom_addr_r <= rom_addr_s;
         if (!dbg_req || dbg_gnt_s) begin
            dbg_wait_r <= 3'd0;
         end else if (dbg_wait_r != STARVE_LIM) begin
            dbg_wait_r <= dbg_wait_r + 3'd1;
         end else begin
            dbg_wait_r <= dbg_wait_r;
         end
      end
   end

   // Response FSM with captured read data.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_r    <= IDLE;
         if_inst_r  <= 32'h0000_0000;
         dbg_data_r <= 32'h0000_0000;
      end else if (if_gnt_s) begin
         state_r   <= IF_RESP;
         if_inst_r <= if_data_s;
      end else if (dbg_gnt_s) begin
         state_r    <= DBG_RESP;
         dbg_data_r <= rom_word_s;
      end else begin
         state_r <= IDLE;
      end
   end

`ifdef FETCH_ALIGN_CHECK_EN
   logic if_adel_r;

   // Misalignment flag captured alongside the fetch data.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         if_adel_r <= 1'b0;
      end else if (if_gnt_s) begin
         if_adel_r <= misalign_s;
      end else begin
         if_adel_r <= if_adel_r;
      end
   end

   assign if_adel = if_adel_r;
`else
   logic unused_pc_lsb_s;
   assign unused_pc_lsb_s = ^if_pc[1:0];
   assign if_adel         = 1'b0;
`endif

   assign if_gnt     = if_gnt_s;
   assign dbg_gnt    = dbg_gnt_s;
   assign rom_addr   = rom_addr_s;
   assign if_rvalid  = state_r[0];
   assign dbg_rvalid = state_r[1];
   assign if_inst    = if_inst_r;
   assign dbg_data   = dbg_data_r;

endmodule

// File: tb/tb_inst_fetch_arbiter.sv
// Directed, table-driven bench for inst_fetch_arbiter with a small behavioural ROM.
module tb_inst_fetch_arbiter;

   logic        clk = 1'b0;
   logic        resetn;
   logic        if_req;
   logic [31:0] if_pc;
   logic        if_gnt;
   logic        if_rvalid;
   logic [31:0] if_inst;
   logic        if_adel;
   logic        dbg_req;
   logic [4:0]  dbg_addr;
   logic        dbg_gnt;
   logic        dbg_rvalid;
   logic [31:0] dbg_data;
   logic [4:0]  rom_addr;
   logic [31:0] rom_inst;

   int tests = 0;
   int fails = 0;
   logic [31:0] exp_inst;
   logic [31:0] exp_dd;

   typedef struct {
      logic        ir;
      logic [31:0] pc;
      logic        dr;
      logic [4:0]  da;
      logic        e_ig;
      logic        e_dg;
      logic [4:0]  e_addr;
      logic        e_irv;
      logic [31:0] e_inst;
      logic        e_adel;
      logic        e_drv;
      logic [31:0] e_dd;
   } vec_t;

   localparam int NV = 13;
   vec_t vecs [NV];

   inst_fetch_arbiter dut (
      .clk        (clk),
      .resetn     (resetn),
      .if_req     (if_req),
      .if_pc      (if_pc),
      .if_gnt     (if_gnt),
      .if_rvalid  (if_rvalid),
      .if_inst    (if_inst),
      .if_adel    (if_adel),
      .dbg_req    (dbg_req),
      .dbg_addr   (dbg_addr),
      .dbg_gnt    (dbg_gnt),
      .dbg_rvalid (dbg_rvalid),
      .dbg_data   (dbg_data),
      .rom_addr   (rom_addr),
      .rom_inst   (rom_inst)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] rom_model(input logic [4:0] a);
      case (a)
         5'd0:    return 32'h2401_0001;
         5'd1:    return 32'h0001_1100;
         5'd23:   return 32'h0800_0000;
         default: return 32'hA5A5_0000 | {27'd0, a};
      endcase
   endfunction

   assign rom_inst = rom_model(rom_addr);

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Caller is at posedge+1: drive, check grants mid-cycle, check responses after the edge.
   task automatic apply(input vec_t v, input string nm);
      if_req   = v.ir;
      if_pc    = v.pc;
      dbg_req  = v.dr;
      dbg_addr = v.da;
      #4;
      chk({nm, ".if_gnt"},   {31'd0, if_gnt},  {31'd0, v.e_ig});
      chk({nm, ".dbg_gnt"},  {31'd0, dbg_gnt}, {31'd0, v.e_dg});
      chk({nm, ".rom_addr"}, {27'd0, rom_addr}, {27'd0, v.e_addr});
      @(posedge clk);
      #1;
      chk({nm, ".if_rvalid"},  {31'd0, if_rvalid},  {31'd0, v.e_irv});
      chk({nm, ".if_inst"},    if_inst,             v.e_inst);
      chk({nm, ".if_adel"},    {31'd0, if_adel},    {31'd0, v.e_adel});
      chk({nm, ".dbg_rvalid"}, {31'd0, dbg_rvalid}, {31'd0, v.e_drv});
      chk({nm, ".dbg_data"},   dbg_data,            v.e_dd);
   endtask

   // Both ports request continuously: debug must win exactly every fifth cycle.
   task automatic starve(input int n, input string nm);
      vec_t v;
      for (int k = 0; k < n; k++) begin
         v.ir = 1'b1; v.pc = 32'h4; v.dr = 1'b1; v.da = 5'd0;
         v.e_adel = 1'b0;
         if ((k % 5) == 4) begin
            exp_dd = 32'h2401_0001;
            v.e_ig = 1'b0; v.e_dg = 1'b1; v.e_addr = 5'd0;
            v.e_irv = 1'b0; v.e_drv = 1'b1;
         end else begin
            exp_inst = 32'h0001_1100;
            v.e_ig = 1'b1; v.e_dg = 1'b0; v.e_addr = 5'd1;
            v.e_irv = 1'b1; v.e_drv = 1'b0;
         end
         v.e_inst = exp_inst;
         v.e_dd   = exp_dd;
         apply(v, $sformatf("%s[%0d]", nm, k));
      end
   endtask

   initial begin
      vec_t idle_v;
      //          ir    pc           dr    da     ig    dg    addr   irv   inst          adel  drv   dd
      vecs[0]  = '{1'b1, 32'h0000_0004, 1'b0, 5'd0,  1'b1, 1'b0, 5'd1,  1'b1, 32'h0001_1100, 1'b0, 1'b0, 32'h0};
      vecs[1]  = '{1'b1, 32'h0000_0000, 1'b0, 5'd0,  1'b1, 1'b0, 5'd0,  1'b1, 32'h2401_0001, 1'b0, 1'b0, 32'h0};
      vecs[2]  = '{1'b1, 32'h0000_0008, 1'b0, 5'd0,  1'b1, 1'b0, 5'd2,  1'b1, 32'hA5A5_0002, 1'b0, 1'b0, 32'h0};
      vecs[3]  = '{1'b1, 32'h0000_005C, 1'b0, 5'd0,  1'b1, 1'b0, 5'd23, 1'b1, 32'h0800_0000, 1'b0, 1'b0, 32'h0};
      vecs[4]  = '{1'b1, 32'h0000_0060, 1'b0, 5'd0,  1'b1, 1'b0, 5'd24, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 32'h0};
      vecs[5]  = '{1'b1, 32'h0000_0084, 1'b0, 5'd0,  1'b1, 1'b0, 5'd1,  1'b1, 32'h0000_0000, 1'b0, 1'b0, 32'h0};
      vecs[6]  = '{1'b1, 32'h0000_005C, 1'b0, 5'd0,  1'b1, 1'b0, 5'd23, 1'b1, 32'h0800_0000, 1'b0, 1'b0, 32'h0};
      vecs[7]  = '{1'b0, 32'h0000_0000, 1'b0, 5'd0,  1'b0, 1'b0, 5'd23, 1'b0, 32'h0800_0000, 1'b0, 1'b0, 32'h0};
      vecs[8]  = '{1'b0, 32'h0000_0000, 1'b1, 5'd30, 1'b0, 1'b1, 5'd30, 1'b0, 32'h0800_0000, 1'b0, 1'b1, 32'h0};
      vecs[9]  = '{1'b0, 32'h0000_0000, 1'b1, 5'd0,  1'b0, 1'b1, 5'd0,  1'b0, 32'h0800_0000, 1'b0, 1'b1, 32'h2401_0001};
      vecs[10] = '{1'b0, 32'h0000_0000, 1'b1, 5'd23, 1'b0, 1'b1, 5'd23, 1'b0, 32'h0800_0000, 1'b0, 1'b1, 32'h0800_0000};
      vecs[11] = '{1'b1, 32'h0000_0004, 1'b0, 5'd0,  1'b1, 1'b0, 5'd1,  1'b1, 32'h0001_1100, 1'b0, 1'b0, 32'h0800_0000};
`ifdef FETCH_ALIGN_CHECK_EN
      vecs[12] = '{1'b1, 32'h0000_0006, 1'b0, 5'd0,  1'b1, 1'b0, 5'd1,  1'b1, 32'h0000_0000, 1'b1, 1'b0, 32'h0800_0000};
`else
      vecs[12] = '{1'b1, 32'h0000_0006, 1'b0, 5'd0,  1'b1, 1'b0, 5'd1,  1'b1, 32'h0001_1100, 1'b0, 1'b0, 32'h0800_0000};
`endif
      idle_v = '{1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0};

      // Reset with both requests active: grants gated, all outputs zero.
      resetn = 1'b0; if_req = 1'b1; if_pc = 32'h4; dbg_req = 1'b1; dbg_addr = 5'd0;
      #2;
      chk("rst.if_gnt",     {31'd0, if_gnt},     32'd0);
      chk("rst.dbg_gnt",    {31'd0, dbg_gnt},    32'd0);
      chk("rst.if_rvalid",  {31'd0, if_rvalid},  32'd0);
      chk("rst.dbg_rvalid", {31'd0, dbg_rvalid}, 32'd0);
      chk("rst.if_inst",    if_inst,             32'd0);
      chk("rst.if_adel",    {31'd0, if_adel},    32'd0);
      chk("rst.dbg_data",   dbg_data,            32'd0);
      chk("rst.rom_addr",   {27'd0, rom_addr},   32'd0);
      @(posedge clk); @(posedge clk); #1;
      resetn = 1'b1;

      for (int i = 0; i < NV; i++) begin
         apply(vecs[i], $sformatf("vec%0d", i));
      end

      exp_inst = vecs[NV-1].e_inst;
      exp_dd   = 32'h0800_0000;
      starve(10, "starve");

      // Build up some debug wait, then reset before a granted fetch is captured.
      starve(2, "pre_rst");
      if_req = 1'b1; if_pc = 32'h4; dbg_req = 1'b1; dbg_addr = 5'd0;
      #4;
      chk("midrst.if_gnt", {31'd0, if_gnt}, 32'd1);
      resetn = 1'b0;
      #1;
      chk("midrst.gated_gnt", {31'd0, if_gnt}, 32'd0);
      @(posedge clk); #1;
      resetn = 1'b1; if_req = 1'b0; dbg_req = 1'b0;
      chk("midrst.if_rvalid", {31'd0, if_rvalid}, 32'd0);
      chk("midrst.if_inst",   if_inst,            32'd0);
      chk("midrst.dbg_data",  dbg_data,           32'd0);
      apply(idle_v, "post_rst_idle");

      // dbg_wait must have been cleared: fetch wins four more times first.
      exp_inst = 32'h0;
      exp_dd   = 32'h0;
      starve(5, "post_rst");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/inst_fetch_arbiter.md
# inst_fetch_arbiter

Owns the address port of the asynchronous instruction ROM. Shares it between the CPU fetch stage and a debug/display peek port, giving one access per cycle. Read data is returned through registered response ports one cycle after grant. Sits between the PC logic, the board debug reader and the ROM.

## Interface
Parameters:
- ROM_DEPTH, 24: number of populated ROM words. Word indices ≥ ROM_DEPTH read as 0.
- STARVE_MAX, 4: number of consecutive denied debug cycles after which debug wins over fetch.

Ports:
- clk  in  1  sole clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held with if_pc until if_gnt
- if_pc  in  32  fetch byte address
- if_gnt  out  1  combinational grant to fetch this cycle
- if_rvalid  out  1  registered; if_inst is valid this cycle
- if_inst  out  32  registered fetch data
- if_adel  out  1  registered misaligned-fetch flag; qualified by if_rvalid
- dbg_req  in  1  debug request; held with dbg_addr until dbg_gnt
- dbg_addr  in  5  debug word index
- dbg_gnt  out  1  combinational grant to debug this cycle
- dbg_rvalid  out  1  registered; dbg_data is valid this cycle
- dbg_data  out  32  registered debug data
- rom_addr  out  5  ROM word index (combinational)
- rom_inst  in  32  ROM data (combinational from rom_addr)

## Operation
Arbitration (combinational, every cycle):
- Only one requester active: it is granted.
- Both active: fetch is granted, unless dbg_wait == STARVE_MAX; then debug is granted.
- if_gnt and dbg_gnt are never high together.

rom_addr:
- Fetch granted: if_pc[6:2].
- Debug granted: dbg_addr.
- No grant: holds its previous value. Reset value is 0.

Out-of-range data:
- Granted data is forced to 32'h0 when the word index is ≥ ROM_DEPTH.
- For fetch, data is also forced to 0 when if_pc[31:7] != 0.

dbg_wait counter (3 bits, saturating at STARVE_MAX):
- Increments each cycle that dbg_req is high and dbg_gnt is low.
- Clears on dbg_gnt, or when dbg_req is low.

Response FSM (state is registered, set by the grant in the previous cycle):
- IDLE: no response presented. Next state is IF_RESP if if_gnt, DBG_RESP if dbg_gnt, otherwise IDLE.
- IF_RESP: if_rvalid = 1. if_inst and if_adel hold the captured values. Next state follows the same grant rule as IDLE.
- DBG_RESP: dbg_rvalid = 1. dbg_data holds the captured value. Next state follows the same grant rule as IDLE.
- Back-to-back grants give back-to-back responses.

Response data registers:
- if_inst and dbg_data keep their last value while their rvalid is low.
- They are updated only on their own grant.

## Timing
- Grant at cycle N: data is captured on the rising edge ending cycle N, and rvalid is high for exactly cycle N+1. Latency is 1 cycle.
- Grant-to-grant throughput is 1 access per cycle.
- The requester drops or changes req/addr after the edge on which gnt was sampled high.
- Reset values (asynchronous, while resetn = 0): if_gnt and dbg_gnt are 0 because they are gated by reset. All other outputs are 0, state is IDLE, dbg_wait is 0.
- Reset asserted mid-access: the pending response is discarded and no rvalid is issued after release.
- First grant is possible in the first cycle with resetn = 1.
- Simultaneous request arrival with dbg_wait < STARVE_MAX: fetch wins.
- Worst-case debug wait is STARVE_MAX + 1 cycles from request to grant.

## Configuration
Macro: FETCH_ALIGN_CHECK_EN.

Defined:
- A granted fetch with if_pc[1:0] != 0 returns if_inst = 0 and if_adel = 1 with if_rvalid.
- The grant still consumes the slot.
- if_adel = 0 for aligned fetches.

Undefined:
- if_pc[1:0] are ignored.
- if_adel is tied to 0.
- No misalignment logic is instantiated.

## Test plan
Bench ROM model: word 0 = 32'h24010001, word 1 = 32'h00011100, word 23 = 32'h08000000.

- Reset, release, then if_req = 1 with if_pc = 32'h4 -> if_gnt in the same cycle; next cycle if_rvalid = 1, if_inst = 32'h00011100. Reset outputs are all 0.
- if_req held high with if_pc stepping 0, 4, 8, ... -> one response per cycle. if_pc = 32'h5C returns 32'h08000000; if_pc = 32'h60 returns 0.
- Both ports request continuously, dbg_addr = 0 -> fetch granted 4 cycles, debug granted on the 5th (dbg_data = 32'h24010001 next cycle). The pattern repeats with period 5.
- dbg_req only, dbg_addr = 5'd30 -> dbg_rvalid = 1 and dbg_data = 0. if_inst is unchanged and if_rvalid = 0.
- Grant issued, then resetn pulled low for half a cycle before the capture edge -> no rvalid after release. State is IDLE and dbg_wait is 0.
- With FETCH_ALIGN_CHECK_EN defined, if_pc = 32'h6 -> if_rvalid = 1, if_adel = 1, if_inst = 0. Without the macro, the same stimulus gives if_adel = 0 and if_inst = 32'h00011100.
